// File: rtl/speed_estimator_if.sv
// Speed estimator pin/bus bundle: enable and encoder pins in, speed sample out.
interface speed_estimator_if #(
    parameter int N = 10
);
    logic                enable;
    logic                enc_a;
    logic                enc_b;
    logic signed [N-1:0] speed;
    logic                speed_valid;
    logic                quad_err;

    modport master (output enable, enc_a, enc_b, input speed, speed_valid, quad_err);
    modport slave  (input enable, enc_a, enc_b, output speed, speed_valid, quad_err);
endinterface

// File: rtl/speed_estimator.sv
// Quadrature encoder speed estimator: windowed signed edge count, moving average
// over 2^AVG_LOG2 windows, scaled and symmetrically clamped to Q(N-F-1).F.
module speed_estimator #(
    parameter int N             = 10,
    parameter int F             = 9,
    parameter int WINDOW_CYCLES = 50000,
    parameter int COUNT_W       = 16,
    parameter int AVG_LOG2      = 2,
    parameter int SCALE_SHIFT   = 4
) (
    input logic              clk,
    input logic              rst,
    speed_estimator_if.slave bus
);
    localparam int D   = 1 << AVG_LOG2;
    localparam int PW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW  = COUNT_W + AVG_LOG2;
    localparam int CW1 = COUNT_W + 1;
    localparam int XW0 = SW + SCALE_SHIFT;
    localparam int XW  = ((XW0 > N) ? XW0 : N) + 1;
    localparam int TW  = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

    localparam logic signed [CW1-1:0] CNT_MAX = CW1'((1 << (COUNT_W - 1)) - 1);
    localparam logic signed [CW1-1:0] CNT_MIN = -CNT_MAX;
    localparam logic signed [XW-1:0]  SPD_MAX = XW'((1 << (N - 1)) - 1);
    localparam logic signed [XW-1:0]  SPD_MIN = -SPD_MAX;

    if (WINDOW_CYCLES < 4 || F > N - 1) begin : g_param_check
        $error("speed_estimator: WINDOW_CYCLES must be >= 4 and F <= N-1");
    end

    logic [1:0]                a_sync, b_sync, sync_fill;
    logic [1:0]                prev_ab, cur_ab, cur_pos, prev_pos, delta;
    logic                      primed, illegal, term;
    logic signed [1:0]         dec;
    logic signed [COUNT_W-1:0] cnt, cnt_sat, win;
    logic signed [CW1-1:0]     cnt_sum;
    logic [TW-1:0]             timer;
    logic [2:0]                vld_pipe;
    logic signed [COUNT_W-1:0] ring [D];
    logic [PW-1:0]             ptr;
    logic signed [SW-1:0]      sum, avg;
    logic signed [XW-1:0]      scaled;
    logic signed [N-1:0]       speed_q, speed_clamped;
    logic                      quad_err_q;

    // Two-flop synchronizers; sync_fill marks when the second stage holds real pin data,
    // so pins already high at reset release are primed instead of decoded against zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync    <= '0;
            b_sync    <= '0;
            sync_fill <= '0;
        end else begin
            a_sync    <= {a_sync[0], bus.enc_a};
            b_sync    <= {b_sync[0], bus.enc_b};
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Gray {A,B} -> position 0..3; forward step is +1 mod 4, a jump of 2 is illegal.
    assign cur_ab   = {a_sync[1], b_sync[1]};
    assign cur_pos  = {cur_ab[1], ^cur_ab};
    assign prev_pos = {prev_ab[1], ^prev_ab};
    assign delta    = cur_pos - prev_pos;

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        if (bus.enable && primed) begin
            case (delta)
                2'd1:    dec = 2'sb01;
                2'd3:    dec = 2'sb11;
                2'd2:    illegal = 1'b1;
                default: dec = '0;
            endcase
        end
    end

    always_comb begin
        cnt_sum = CW1'(cnt) + CW1'(dec);
        cnt_sat = cnt_sum[COUNT_W-1:0];
        if (cnt_sum > CNT_MAX)      cnt_sat = CNT_MAX[COUNT_W-1:0];
        else if (cnt_sum < CNT_MIN) cnt_sat = CNT_MIN[COUNT_W-1:0];
    end

    assign term = bus.enable && (timer == TW'(WINDOW_CYCLES - 1));

    always_comb begin
        avg           = sum >>> AVG_LOG2;
        scaled        = XW'(avg) <<< SCALE_SHIFT;
        speed_clamped = scaled[N-1:0];
        if (scaled > SPD_MAX)      speed_clamped = SPD_MAX[N-1:0];
        else if (scaled < SPD_MIN) speed_clamped = SPD_MIN[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab    <= '0;
            primed     <= 1'b0;
            timer      <= '0;
            cnt        <= '0;
            win        <= '0;
            vld_pipe   <= '0;
            ptr        <= '0;
            sum        <= '0;
            speed_q    <= '0;
            quad_err_q <= 1'b0;
            for (int i = 0; i < D; i++) ring[i] <= '0;
        end else if (!bus.enable) begin
            primed     <= 1'b0;
            timer      <= '0;
            cnt        <= '0;
            win        <= '0;
            vld_pipe   <= '0;
            ptr        <= '0;
            sum        <= '0;
            speed_q    <= '0;
            quad_err_q <= 1'b0;
            for (int i = 0; i < D; i++) ring[i] <= '0;
        end else begin
            if (sync_fill[1]) begin
                prev_ab <= cur_ab;
                primed  <= 1'b1;
            end
            if (illegal) quad_err_q <= 1'b1;
            vld_pipe <= {vld_pipe[1:0], term};
            // The terminal cycle's own edge opens the next window.
            if (term) begin
                timer <= '0;
                win   <= cnt;
                cnt   <= COUNT_W'(dec);
            end else begin
                timer <= timer + 1'b1;
                cnt   <= cnt_sat;
            end
            if (vld_pipe[0]) begin
                sum       <= sum + SW'(win) - SW'(ring[ptr]);
                ring[ptr] <= win;
                ptr       <= (ptr == PW'(D - 1)) ? '0 : ptr + 1'b1;
            end
            if (vld_pipe[1]) speed_q <= speed_clamped;
        end
    end

    assign bus.speed       = speed_q;
    assign bus.speed_valid = vld_pipe[2];
    assign bus.quad_err    = quad_err_q;
endmodule

// File: tb/tb_speed_estimator.sv
// Directed bench for speed_estimator at WINDOW_CYCLES=100, ring depth 4, shift 4, Q0.9.
module tb_speed_estimator;
    localparam int N = 10;
    localparam int W = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    speed_estimator_if #(.N(N)) bus();

    speed_estimator #(
        .N(N), .F(9), .WINDOW_CYCLES(W), .COUNT_W(16), .AVG_LOG2(2), .SCALE_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cyc0  = 0;
    int per   = 0;
    int ph    = 0;
    int dir   = 1;
    logic [1:0] pos = 2'd0;
    logic signed [N-1:0] pv[$];
    int pc[$];

    task automatic drive_pins();
        bus.enc_a = pos[1];
        bus.enc_b = pos[1] ^ pos[0];
    endtask

    task automatic step(input int d);
        pos = (d > 0) ? pos + 2'd1 : pos + 2'd3;
        drive_pins();
    endtask

    // One clock: sample outputs 1 time unit after the edge, then advance the encoder.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (bus.speed_valid === 1'b1) begin
            pv.push_back(bus.speed);
            pc.push_back(cyc);
        end
        if (per != 0) begin
            ph++;
            if (ph >= per) begin
                ph = 0;
                step(dir);
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Clear the block, then raise enable; cyc0 is the edge just before enable is seen.
    task automatic start(input int p, input int d);
        per = 0;
        bus.enable = 1'b0;
        ticks(3);
        pv.delete();
        pc.delete();
        bus.enable = 1'b1;
        cyc0 = cyc;
        per = p;
        dir = d;
        ph  = p - 1;
    endtask

    task automatic test_reset();
        ticks(2);
        total++;
        if (bus.speed !== '0 || bus.speed_valid !== 1'b0 || bus.quad_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got speed=%0d valid=%b qerr=%b exp 0/0/0",
                     bus.speed, bus.speed_valid, bus.quad_err);
        end
        rst = 1'b0;
        ticks(2);
    endtask

    task automatic test_forward_flip();
        logic signed [N-1:0] e [10] = '{80, 160, 240, 320, 320, 160, 0, -160, -320, -320};
        start(5, 1);
        ticks(502);
        dir = -1;
        ticks(500);
        total++;
        if (pv.size() != 10) begin
            bad++;
            $display("FAIL fwd_pulse_count got=%0d exp=10", pv.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (pv[i] !== e[i] || pc[i] - cyc0 !== 102 + 100 * i) begin
                    bad++;
                    $display("FAIL fwd_flip[%0d] got speed=%0d at=%0d exp speed=%0d at=%0d",
                             i, pv[i], pc[i] - cyc0, e[i], 102 + 100 * i);
                end
            end
        end
    endtask

    task automatic test_reverse_floor();
        logic signed [N-1:0] e [5] = '{-48, -80, -128, -160, -160};
        start(10, -1);
        ticks(502);
        total++;
        if (pv.size() != 5) begin
            bad++;
            $display("FAIL rev_pulse_count got=%0d exp=5", pv.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (pv[i] !== e[i]) begin
                    bad++;
                    $display("FAIL rev_floor[%0d] got=%0d exp=%0d", i, pv[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_clamp();
        logic signed [N-1:0] e [11] = '{192, 384, 511, 511, 511, 416, 16, -384, -511, -511, -511};
        start(2, 1);
        ticks(502);
        dir = -1;
        ticks(600);
        total++;
        if (pv.size() != 11) begin
            bad++;
            $display("FAIL clamp_pulse_count got=%0d exp=11", pv.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                total++;
                if (pv[i] !== e[i]) begin
                    bad++;
                    $display("FAIL clamp[%0d] got=%0d exp=%0d", i, pv[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_quad_err();
        start(0, 1);
        ticks(5);
        repeat (3) begin
            step(1);
            tick();
        end
        pos = pos + 2'd2;
        drive_pins();
        ticks(2);
        total++;
        if (bus.quad_err !== 1'b0) begin
            bad++;
            $display("FAIL qerr_latency got=%b exp=0", bus.quad_err);
        end
        tick();
        total++;
        if (bus.quad_err !== 1'b1) begin
            bad++;
            $display("FAIL qerr_set got=%b exp=1", bus.quad_err);
        end
        step(1);
        ticks(10);
        total++;
        if (bus.quad_err !== 1'b1) begin
            bad++;
            $display("FAIL qerr_sticky got=%b exp=1", bus.quad_err);
        end
        ticks(102 - (cyc - cyc0));
        total++;
        if (pv.size() != 1 || pv[0] !== 16) begin
            bad++;
            $display("FAIL qerr_count got pulses=%0d speed=%0d exp pulses=1 speed=16",
                     pv.size(), (pv.size() > 0) ? int'(pv[0]) : 0);
        end
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        total++;
        if (bus.quad_err !== 1'b0 || bus.speed !== '0) begin
            bad++;
            $display("FAIL qerr_clear got qerr=%b speed=%0d exp 0/0", bus.quad_err, bus.speed);
        end
    endtask

    task automatic test_terminal_edge();
        logic signed [N-1:0] e [2] = '{16, 32};
        start(0, 1);
        ticks(90);
        // Eight consecutive edges; the last lands on the terminal cycle.
        repeat (8) begin
            step(1);
            tick();
        end
        ticks(202 - (cyc - cyc0));
        total++;
        if (pv.size() != 2) begin
            bad++;
            $display("FAIL term_pulse_count got=%0d exp=2", pv.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (pv[i] !== e[i]) begin
                    bad++;
                    $display("FAIL term_edge[%0d] got=%0d exp=%0d", i, pv[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_reset_pins_high();
        per = 0;
        bus.enable = 1'b0;
        rst = 1'b1;
        pos = 2'd2;
        drive_pins();
        ticks(3);
        bus.enable = 1'b1;
        rst = 1'b0;
        pv.delete();
        pc.delete();
        cyc0 = cyc;
        ticks(102);
        total++;
        if (pv.size() != 1 || pc[0] - cyc0 !== 102 || pv[0] !== 0 || bus.quad_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_pins_high got pulses=%0d speed=%0d qerr=%b exp pulses=1 speed=0 qerr=0",
                     pv.size(), (pv.size() > 0) ? int'(pv[0]) : 0, bus.quad_err);
        end
    endtask

    task automatic test_abort_restart();
        start(5, 1);
        ticks(250);
        #3 rst = 1'b1;
        #1;
        total++;
        if (bus.speed !== '0 || bus.speed_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got speed=%0d valid=%b exp 0/0", bus.speed, bus.speed_valid);
        end
        tick();
        rst = 1'b0;
        pv.delete();
        pc.delete();
        cyc0 = cyc;
        ticks(101);
        total++;
        if (pv.size() != 0) begin
            bad++;
            $display("FAIL rst_early_valid got pulses=%0d exp=0", pv.size());
        end
        tick();
        total++;
        if (pv.size() != 1 || pc[0] - cyc0 !== 102) begin
            bad++;
            $display("FAIL rst_first_valid got pulses=%0d exp=1 at 102", pv.size());
        end
        ticks(50);
        bus.enable = 1'b0;
        tick();
        total++;
        if (bus.speed !== '0 || bus.speed_valid !== 1'b0) begin
            bad++;
            $display("FAIL en_low_clear got speed=%0d valid=%b exp 0/0", bus.speed, bus.speed_valid);
        end
        bus.enable = 1'b1;
        pv.delete();
        pc.delete();
        cyc0 = cyc;
        ticks(101);
        total++;
        if (pv.size() != 0) begin
            bad++;
            $display("FAIL reen_early_valid got pulses=%0d exp=0", pv.size());
        end
        tick();
        total++;
        if (pv.size() != 1 || pc[0] - cyc0 !== 102) begin
            bad++;
            $display("FAIL reen_first_valid got pulses=%0d exp=1 at 102", pv.size());
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.enc_a  = 1'b0;
        bus.enc_b  = 1'b0;
        test_reset();
        test_forward_flip();
        test_reverse_floor();
        test_clamp();
        test_quad_err();
        test_terminal_edge();
        test_reset_pins_high();
        test_abort_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
